// File: rtl/id_ex_hazard_stage_if.sv
// ID -> ID/EX stage bundle: decoded ID-side inputs, registered EX-side outputs and stall.
// The DUT takes the slave modport; whoever drives ID and EX-flush uses master.
interface id_ex_hazard_stage_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ALUOP_W = 4
);
  logic               ifIdValid;
  logic [XLEN-1:0]    ifIdPc;
  logic [4:0]         ifIdRs1;
  logic [4:0]         ifIdRs2;
  logic [4:0]         ifIdRd;
  logic               usesRs1;
  logic               usesRs2;
  logic [XLEN-1:0]    rdData1;
  logic [XLEN-1:0]    rdData2;
  logic [XLEN-1:0]    immIn;
  logic               ctrlRegWrite;
  logic               ctrlMemRead;
  logic               ctrlMemWrite;
  logic               ctrlMemToReg;
  logic               ctrlAluSrc;
  logic [ALUOP_W-1:0] ctrlAluOp;
  logic               exFlush;

  logic               stall;
  logic               idExValid;
  logic [XLEN-1:0]    idExPc;
  logic [4:0]         idExRs1;
  logic [4:0]         idExRs2;
  logic [4:0]         idExRd;
  logic [XLEN-1:0]    idExData1;
  logic [XLEN-1:0]    idExData2;
  logic [XLEN-1:0]    idExImm;
  logic               idExRegWrite;
  logic               idExMemRead;
  logic               idExMemWrite;
  logic               idExMemToReg;
  logic               idExAluSrc;
  logic [ALUOP_W-1:0] idExAluOp;

  modport master (
    output ifIdValid, ifIdPc, ifIdRs1, ifIdRs2, ifIdRd, usesRs1, usesRs2,
           rdData1, rdData2, immIn, ctrlRegWrite, ctrlMemRead, ctrlMemWrite,
           ctrlMemToReg, ctrlAluSrc, ctrlAluOp, exFlush,
    input  stall, idExValid, idExPc, idExRs1, idExRs2, idExRd, idExData1,
           idExData2, idExImm, idExRegWrite, idExMemRead, idExMemWrite,
           idExMemToReg, idExAluSrc, idExAluOp
  );

  modport slave (
    input  ifIdValid, ifIdPc, ifIdRs1, ifIdRs2, ifIdRd, usesRs1, usesRs2,
           rdData1, rdData2, immIn, ctrlRegWrite, ctrlMemRead, ctrlMemWrite,
           ctrlMemToReg, ctrlAluSrc, ctrlAluOp, exFlush,
    output stall, idExValid, idExPc, idExRs1, idExRs2, idExRd, idExData1,
           idExData2, idExImm, idExRegWrite, idExMemRead, idExMemWrite,
           idExMemToReg, idExAluSrc, idExAluOp
  );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall and bubble insertion on stall or EX flush.
// Optional: define BUBBLE_COUNT_EN to add a saturating 16-bit bubbleCount output.
module id_ex_hazard_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ALUOP_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  id_ex_hazard_stage_if.slave  bus
`ifdef BUBBLE_COUNT_EN
  ,
  output logic [15:0]          bubbleCount
`endif
);

  logic               valid_q, valid_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [4:0]         rs1_q, rs1_d;
  logic [4:0]         rs2_q, rs2_d;
  logic [4:0]         rd_q, rd_d;
  logic [XLEN-1:0]    data1_q, data1_d;
  logic [XLEN-1:0]    data2_q, data2_d;
  logic [XLEN-1:0]    imm_q, imm_d;
  logic               reg_write_q, reg_write_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic               mem_to_reg_q, mem_to_reg_d;
  logic               alu_src_q, alu_src_d;
  logic [ALUOP_W-1:0] alu_op_q, alu_op_d;

  logic hazard;
  logic stall;
  logic load_bubble;

  // Only a load already in EX can fail to forward; rd = 0 never produces a value.
  assign hazard = valid_q & mem_read_q & (rd_q != 5'd0) & bus.ifIdValid &
                  ((bus.usesRs1 & (rd_q == bus.ifIdRs1)) |
                   (bus.usesRs2 & (rd_q == bus.ifIdRs2)));
  assign stall       = hazard & ~bus.exFlush;
  assign load_bubble = stall | bus.exFlush;

  always_comb begin
    valid_d      = 1'b0;
    pc_d         = '0;
    rs1_d        = '0;
    rs2_d        = '0;
    rd_d         = '0;
    data1_d      = '0;
    data2_d      = '0;
    imm_d        = '0;
    reg_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    alu_src_d    = 1'b0;
    alu_op_d     = '0;
    if (!load_bubble) begin
      valid_d = bus.ifIdValid;
      pc_d    = bus.ifIdPc;
      rs1_d   = bus.ifIdRs1;
      rs2_d   = bus.ifIdRs2;
      rd_d    = bus.ifIdRd;
      data1_d = bus.rdData1;
      data2_d = bus.rdData2;
      imm_d   = bus.immIn;
      // An invalid ID slot still moves its fields but carries no control.
      if (bus.ifIdValid) begin
        reg_write_d  = bus.ctrlRegWrite;
        mem_read_d   = bus.ctrlMemRead;
        mem_write_d  = bus.ctrlMemWrite;
        mem_to_reg_d = bus.ctrlMemToReg;
        alu_src_d    = bus.ctrlAluSrc;
        alu_op_d     = bus.ctrlAluOp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      data1_q      <= '0;
      data2_q      <= '0;
      imm_q        <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_op_q     <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      imm_q        <= imm_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_src_q    <= alu_src_d;
      alu_op_q     <= alu_op_d;
    end
  end

  assign bus.stall        = stall;
  assign bus.idExValid    = valid_q;
  assign bus.idExPc       = pc_q;
  assign bus.idExRs1      = rs1_q;
  assign bus.idExRs2      = rs2_q;
  assign bus.idExRd       = rd_q;
  assign bus.idExData1    = data1_q;
  assign bus.idExData2    = data2_q;
  assign bus.idExImm      = imm_q;
  assign bus.idExRegWrite = reg_write_q;
  assign bus.idExMemRead  = mem_read_q;
  assign bus.idExMemWrite = mem_write_q;
  assign bus.idExMemToReg = mem_to_reg_q;
  assign bus.idExAluSrc   = alu_src_q;
  assign bus.idExAluOp    = alu_op_q;

`ifdef BUBBLE_COUNT_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (load_bubble && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubbleCount = bubble_cnt_q;
`endif

endmodule
